// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM memory fields into an aligned data-memory
// request, stalls until the response arrives, then presents extended load data to MEM/WB.
`timescale 1ns/1ps

module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic        advance_i,
  output logic [31:0] dmem_address_o,
  output logic        dmem_read_o,
  output logic        dmem_write_o,
  output logic [3:0]  dmem_wmask_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_resp_i,
  output logic [31:0] mem_data_out_o,
  output logic        mem_stall_o,
  output logic        access_fault_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_next;

  logic        access_req;
  logic        illegal_f3;
  logic        misaligned;
  logic        fault;
  logic        start;
  logic [3:0]  mask_next;
  logic [31:0] wdata_next;

  logic        read_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [1:0]  off_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [31:0] data_q;

  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;

  // Decode the instruction sitting in EX/MEM: legality, alignment and lane placement.
  always_comb begin
    access_req = in_valid_i & (mem_read_i | mem_write_i);
    if (mem_read_i)
      illegal_f3 = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    else
      illegal_f3 = funct3_i[2] || (funct3_i[1:0] == 2'b11);
    case (funct3_i[1:0])
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    fault = access_req & (illegal_f3 | misaligned);
    start = (state == IDLE) & access_req & ~fault;
    case (funct3_i[1:0])
      2'b00:   mask_next = 4'b0001 << addr_i[1:0];
      2'b01:   mask_next = 4'b0011 << addr_i[1:0];
      default: mask_next = 4'b1111;
    endcase
    wdata_next = store_data_i << {addr_i[1:0], 3'b000};
  end

  always_comb begin
    rdata_shifted = dmem_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_ext = {24'b0, rdata_shifted[7:0]};
      3'b101:  load_ext = {16'b0, rdata_shifted[15:0]};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCESS;
      ACCESS:  if (dmem_resp_i) state_next = DONE;
      DONE:    if (advance_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    mem_stall_o    = start | (state == ACCESS);
    mem_data_out_o = (state == DONE) ? data_q : 32'b0;
    access_fault_o = fault;
  end

  // The request is launched from registers so the memory sees it stable for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= 32'b0;
      off_q    <= 2'b0;
      mask_q   <= 4'b0;
      wdata_q  <= 32'b0;
      funct3_q <= 3'b0;
      data_q   <= 32'b0;
    end else begin
      state <= state_next;
      if (start) begin
        read_q   <= mem_read_i;
        write_q  <= mem_write_i;
        addr_q   <= {addr_i[31:2], 2'b00};
        off_q    <= addr_i[1:0];
        mask_q   <= mask_next;
        wdata_q  <= mem_write_i ? wdata_next : 32'b0;
        funct3_q <= funct3_i;
      end
      if ((state == ACCESS) && dmem_resp_i) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
        data_q  <= read_q ? load_ext : 32'b0;
      end
    end
  end

  assign dmem_address_o = addr_q;
  assign dmem_read_o    = read_q;
  assign dmem_write_o   = write_q;
  assign dmem_wmask_o   = mask_q;
  assign dmem_wdata_o   = wdata_q;

endmodule
